// File: rtl/ff_bank_pkg.sv
// Shared constants for the multi-mode flip-flop bank.
// Mode encodings, S=R=1 policies and the policy resolution helper.
package ff_bank_pkg;

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam int POL_HOLD = 0;
    localparam int POL_SET  = 1;
    localparam int POL_RST  = 2;

    function automatic logic sr_resolve(input int pol, input logic q);
        unique case (1'b1)
            (pol == POL_SET): sr_resolve = 1'b1;
            (pol == POL_RST): sr_resolve = 1'b0;
            default:          sr_resolve = q;
        endcase
    endfunction

endpackage

// File: rtl/ff_bit_next.sv
// Combinational next-state function of one bank bit.
// Ports: q current state, a/b data inputs, mode; next state, illegal (SR with S=R=1).
module ff_bit_next
    import ff_bank_pkg::*;
#(
    parameter int ILLEGAL_POLICY = POL_HOLD
) (
    input  logic       q,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] mode,
    output logic       next,
    output logic       illegal
);

    always_comb begin
        next    = q;
        illegal = 1'b0;
        unique case (1'b1)
            (mode == MODE_D): next = a;
            (mode == MODE_T): next = q ^ a;
            (mode == MODE_JK): begin
                unique case ({a, b})
                    2'b10:   next = 1'b1;
                    2'b01:   next = 1'b0;
                    2'b11:   next = ~q;
                    default: next = q;
                endcase
            end
            (mode == MODE_SR): begin
                unique case ({a, b})
                    2'b10:   next = 1'b1;
                    2'b01:   next = 1'b0;
                    2'b11: begin
                        next    = sr_resolve(ILLEGAL_POLICY, q);
                        illegal = 1'b1;
                    end
                    default: next = q;
                endcase
            end
            default: next = q;
        endcase
    end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit D/T/JK/SR flip-flop bank with illegal-input tracking and change counter.
// Ports: clk, rst, en, mode, a, b, clr_err, clr_cnt; q, nq, illegal, illegal_sticky, illegal_mask, chg_count.
module multi_mode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int ILLEGAL_POLICY = POL_HOLD,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             illegal,
    output logic             illegal_sticky,
    output logic [WIDTH-1:0] illegal_mask,
    output logic [CNT_W-1:0] chg_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] ill_bits;
    logic [WIDTH-1:0] ill_evt;
    logic             illegal_now;
    logic             changed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_bit_next #(
            .ILLEGAL_POLICY(ILLEGAL_POLICY)
        ) u_next (
            .q      (q[i]),
            .a      (a[i]),
            .b      (b[i]),
            .mode   (mode),
            .next   (next_q[i]),
            .illegal(ill_bits[i])
        );
    end

    // Frozen bank sees no illegal events and no changes.
    assign ill_evt     = en ? ill_bits : '0;
    assign illegal_now = |ill_evt;
    assign changed     = en && (next_q != q);

    // Inverse of the state register; can never equal q.
    assign nq = ~q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q              <= '0;
            illegal        <= 1'b0;
            illegal_sticky <= 1'b0;
            illegal_mask   <= '0;
            chg_count      <= '0;
        end else begin
            if (en) begin
                q <= next_q;
            end
            illegal <= illegal_now;
            // A same-edge event survives the clear; older history does not.
            if (clr_err) begin
                illegal_sticky <= illegal_now;
                illegal_mask   <= ill_evt;
            end else begin
                illegal_sticky <= illegal_sticky | illegal_now;
                illegal_mask   <= illegal_mask | ill_evt;
            end
            if (clr_cnt) begin
                chg_count <= changed ? CNT_ONE : '0;
            end else if (changed && chg_count != CNT_MAX) begin
                chg_count <= chg_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Scoreboard bench: three bank instances (policies hold/set/reset) against a reference model.
// Stimulus pushes expected outputs; a monitor pops and compares after every edge.
module tb_multi_mode_ff_bank;

    typedef struct packed {
        logic [7:0]  q;
        logic [7:0]  nq;
        logic        ill;
        logic        st;
        logic [7:0]  mask;
        logic [15:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, clr_err, clr_cnt;
    logic [1:0] mode;
    logic [7:0] a, b;

    logic [7:0]  q0, nq0, mk0, q1, nq1, mk1, q2, nq2, mk2;
    logic        il0, st0, il1, st1, il2, st2;
    logic [15:0] cc0;
    logic [1:0]  cc1;
    logic [2:0]  cc2;

    int total = 0;
    int bad   = 0;

    exp_t sbq0[$];
    exp_t sbq1[$];
    exp_t sbq2[$];

    int          pol[3] = '{0, 1, 2};
    int          cw[3]  = '{16, 2, 3};
    logic [7:0]  mq[3];
    logic [7:0]  mmask[3];
    logic        mill[3];
    logic        mst[3];
    int unsigned mcnt[3];

    always #5 clk = ~clk;

    multi_mode_ff_bank #(.WIDTH(8), .ILLEGAL_POLICY(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .clr_cnt(clr_cnt), .q(q0), .nq(nq0),
        .illegal(il0), .illegal_sticky(st0), .illegal_mask(mk0),
        .chg_count(cc0));

    multi_mode_ff_bank #(.WIDTH(8), .ILLEGAL_POLICY(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .clr_cnt(clr_cnt), .q(q1), .nq(nq1),
        .illegal(il1), .illegal_sticky(st1), .illegal_mask(mk1),
        .chg_count(cc1));

    multi_mode_ff_bank #(.WIDTH(8), .ILLEGAL_POLICY(2), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .clr_cnt(clr_cnt), .q(q2), .nq(nq2),
        .illegal(il2), .illegal_sticky(st2), .illegal_mask(mk2),
        .chg_count(cc2));

    // Reference: per-bit truth tables applied to the current inputs.
    function automatic logic ref_bit(int k, logic qb, logic ab, logic bb);
        case (mode)
            2'd0: return ab;
            2'd1: return qb ^ ab;
            2'd2: begin
                if (ab && bb) return ~qb;
                if (ab) return 1'b1;
                if (bb) return 1'b0;
                return qb;
            end
            default: begin
                if (ab && bb) begin
                    if (pol[k] == 1) return 1'b1;
                    if (pol[k] == 2) return 1'b0;
                    return qb;
                end
                if (ab) return 1'b1;
                if (bb) return 1'b0;
                return qb;
            end
        endcase
    endfunction

    task automatic model_update();
        exp_t        e;
        logic [7:0]  nxt;
        logic [7:0]  both;
        logic        ev;
        logic        chg;
        int unsigned cmax;
        for (int k = 0; k < 3; k++) begin
            cmax = (1 << cw[k]) - 1;
            if (rst) begin
                mq[k] = 8'h00; mmask[k] = 8'h00;
                mill[k] = 1'b0; mst[k] = 1'b0; mcnt[k] = 0;
            end else begin
                nxt = mq[k];
                if (en) begin
                    for (int i = 0; i < 8; i++)
                        nxt[i] = ref_bit(k, mq[k][i], a[i], b[i]);
                end
                both = a & b;
                ev   = en && (mode == 2'd3) && (both != 8'h00);
                chg  = en && (nxt != mq[k]);
                if (clr_cnt) mcnt[k] = chg ? 1 : 0;
                else if (chg && mcnt[k] < cmax) mcnt[k] = mcnt[k] + 1;
                if (clr_err) begin
                    mst[k]   = ev;
                    mmask[k] = ev ? both : 8'h00;
                end else begin
                    mst[k] = mst[k] | ev;
                    if (ev) mmask[k] = mmask[k] | both;
                end
                mill[k] = ev;
                mq[k]   = nxt;
            end
            e.q = mq[k]; e.nq = ~mq[k]; e.ill = mill[k]; e.st = mst[k];
            e.mask = mmask[k]; e.cnt = 16'(mcnt[k]);
            case (k)
                0: sbq0.push_back(e);
                1: sbq1.push_back(e);
                default: sbq2.push_back(e);
            endcase
        end
    endtask

    function automatic exp_t act(int k);
        exp_t g;
        case (k)
            0: g = '{q0, nq0, il0, st0, mk0, cc0};
            1: g = '{q1, nq1, il1, st1, mk1, {14'd0, cc1}};
            default: g = '{q2, nq2, il2, st2, mk2, {13'd0, cc2}};
        endcase
        return g;
    endfunction

    task automatic cmp(int k, exp_t e);
        exp_t g;
        g = act(k);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL sb dut%0d t=%0t got q=%h nq=%h il=%b st=%b mk=%h cnt=%0d want q=%h nq=%h il=%b st=%b mk=%h cnt=%0d",
                     k, $time, g.q, g.nq, g.ill, g.st, g.mask, g.cnt,
                     e.q, e.nq, e.ill, e.st, e.mask, e.cnt);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq0.size() > 0) cmp(0, sbq0.pop_front());
            if (sbq1.size() > 0) cmp(1, sbq1.pop_front());
            if (sbq2.size() > 0) cmp(2, sbq2.pop_front());
        end
    end

    task automatic dchk(string name, logic [15:0] got, logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] aa, input logic [7:0] bb,
                        input logic ce, input logic cc);
        rst = r; en = e; mode = m; a = aa; b = bb;
        clr_err = ce; clr_cnt = cc;
        model_update();
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(1, 1, 2'd0, 8'hFF, 8'h00, 0, 0);
        step(1, 1, 2'd0, 8'hFF, 8'h00, 0, 0);
        dchk("rst_q", 16'(q0), 16'h00);
        dchk("rst_nq", 16'(nq0), 16'hFF);
        dchk("rst_cnt", cc0, 16'd0);
        dchk("rst_st", 16'(st0), 16'd0);

        step(0, 1, 2'd0, 8'hA5, 8'h00, 0, 0);
        dchk("d_q", 16'(q0), 16'hA5);
        step(0, 1, 2'd1, 8'h0F, 8'h00, 0, 0);
        dchk("t_q", 16'(q0), 16'hAA);
        dchk("t_cnt", cc0, 16'd2);
        step(0, 1, 2'd1, 8'h00, 8'h00, 0, 0);
        dchk("t0_q", 16'(q0), 16'hAA);
        dchk("t0_cnt", cc0, 16'd2);

        step(0, 1, 2'd0, 8'h0F, 8'h00, 0, 0);
        step(0, 1, 2'd2, 8'hF0, 8'h3C, 0, 0);
        dchk("jk_q", 16'(q0), 16'hF3);

        step(0, 1, 2'd0, 8'h00, 8'h00, 0, 0);
        step(0, 1, 2'd3, 8'h81, 8'h01, 0, 0);
        dchk("sr1_q", 16'(q1), 16'h81);
        dchk("sr1_ill", 16'(il1), 16'd1);
        dchk("sr1_mask", 16'(mk1), 16'h01);
        dchk("sr1_st", 16'(st1), 16'd1);
        dchk("sr0_q", 16'(q0), 16'h80);
        dchk("sr2_q", 16'(q2), 16'h80);
        step(0, 1, 2'd3, 8'h00, 8'h00, 0, 0);
        dchk("sr_ill_drop", 16'(il1), 16'd0);
        dchk("sr_st_keep", 16'(st1), 16'd1);
        step(0, 0, 2'd3, 8'h00, 8'h00, 1, 0);
        dchk("clr_st", 16'(st1), 16'd0);
        dchk("clr_mask", 16'(mk1), 16'h00);
        step(0, 1, 2'd3, 8'h01, 8'h01, 0, 0);
        step(0, 1, 2'd3, 8'h04, 8'h04, 1, 0);
        dchk("clr_new_mask", 16'(mk1), 16'h04);
        dchk("clr_new_st", 16'(st1), 16'd1);

        step(1, 0, 2'd0, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'd1, 8'h01, 8'h00, 0, 0);
        dchk("sat_cnt", 16'(cc1), 16'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 2'd1, 8'hFF, 8'h00, 0, 0);
        dchk("en0_q", 16'(q1), 16'h01);
        dchk("en0_cnt", 16'(cc1), 16'd3);
        step(0, 1, 2'd1, 8'h01, 8'h00, 0, 1);
        dchk("clrcnt_chg", 16'(cc1), 16'd1);

        step(1, 0, 2'd0, 8'h00, 8'h00, 0, 0);
        step(0, 1, 2'd3, 8'h01, 8'h01, 0, 0);
        dchk("hold_ill_cnt", cc0, 16'd0);
        dchk("hold_ill", 16'(il0), 16'd1);
        for (int i = 0; i < 5; i++) step(0, 1, 2'd1, 8'h01, 8'h00, 0, 0);
        dchk("pre_rst_cnt", cc0, 16'd5);
        step(1, 1, 2'd1, 8'hFF, 8'hFF, 1, 1);
        dchk("mid_rst_q", 16'(q0), 16'h00);
        dchk("mid_rst_cnt", cc0, 16'd0);
        dchk("mid_rst_st", 16'(st0), 16'd0);
        dchk("mid_rst_mask", 16'(mk0), 16'h00);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
        end
        step(0, 0, 2'd0, 8'h00, 8'h00, 0, 0);
        @(posedge clk);
        #2;
        total++;
        if (sbq0.size() + sbq1.size() + sbq2.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0",
                     sbq0.size() + sbq1.size() + sbq2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
